// File: rtl/vec_pair_packer.sv
// Gathers six scalar words from an FWFT FIFO into x[2:0]/y[2:0] and pushes the
// completed vector pair as a single write into the vector FIFO of the dot stage.
module vec_pair_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   in_dout,
  input  logic                    in_empty,
  output logic                    in_rd_en,
  output logic [3*DATA_WIDTH-1:0] out_x,
  output logic [3*DATA_WIDTH-1:0] out_y,
  input  logic                    out_full,
  output logic                    out_wr_en,
  output logic [CNT_WIDTH-1:0]    pairs_written
);

  typedef enum logic {
    COLLECT = 1'b0,
    WRITE   = 1'b1
  } state_t;

  localparam logic [2:0] LAST_SLOT = 3'd5;

  state_t     state, state_nxt;
  logic [2:0] slot, slot_nxt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its inputs, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= COLLECT;
      slot  <= 3'd0;
    end else begin
      state <= state_nxt;
      slot  <= slot_nxt;
    end
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    slot_nxt  = slot;
    in_rd_en  = 1'b0;
    out_wr_en = 1'b0;
    if (!reset) begin
      unique case (state)
        COLLECT: begin
          if (!in_empty) begin
            in_rd_en = 1'b1;
            if (slot == LAST_SLOT) begin
              slot_nxt  = 3'd0;
              state_nxt = WRITE;
            end else begin
              slot_nxt = slot + 3'd1;
            end
          end
        end
        WRITE: begin
          if (!out_full) begin
            out_wr_en = 1'b1;
            state_nxt = COLLECT;
          end
        end
        default: state_nxt = COLLECT;
      endcase
    end
  end

  // Slots 0..2 land in x lanes 0..2, slots 3..5 in y lanes 0..2.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_x         <= '0;
      out_y         <= '0;
      pairs_written <= '0;
    end else begin
      if (in_rd_en) begin
        for (int i = 0; i < 3; i++) begin
          if (slot == 3'(i))     out_x[i*DATA_WIDTH +: DATA_WIDTH] <= in_dout;
          if (slot == 3'(i + 3)) out_y[i*DATA_WIDTH +: DATA_WIDTH] <= in_dout;
        end
      end
      if (out_wr_en) pairs_written <= pairs_written + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_vec_pair_packer.sv
// Directed bench for vec_pair_packer: an upstream word queue feeds the DUT and
// a scoreboard of expected pairs is compared against every vector FIFO write.
module tb_vec_pair_packer;
  localparam int W  = 32;
  localparam int CW = 4;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [W-1:0]   in_dout;
  logic           in_empty;
  logic           in_rd_en;
  logic [3*W-1:0] out_x;
  logic [3*W-1:0] out_y;
  logic           out_full;
  logic           out_wr_en;
  logic [CW-1:0]  pairs_written;

  vec_pair_packer #(.DATA_WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clock         (clock),
    .reset         (reset),
    .in_dout       (in_dout),
    .in_empty      (in_empty),
    .in_rd_en      (in_rd_en),
    .out_x         (out_x),
    .out_y         (out_y),
    .out_full      (out_full),
    .out_wr_en     (out_wr_en),
    .pairs_written (pairs_written)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3*W-1:0] x;
    logic [3*W-1:0] y;
  } pair_t;

  pair_t        sb_q[$];
  logic [W-1:0] src_q[$];
  int           pop_cyc[$];
  int           write_cyc[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc    = 0;
  int           writes = 0;
  int           pops   = 0;
  logic [CW-1:0] exp_pairs = '0;
  logic         hold_inputs = 1'b0;
  logic         sparse = 1'b0;
  logic         gap    = 1'b0;
  logic         last_rd, last_wr;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_pair(input logic [W-1:0] w0, input logic [W-1:0] w1, input logic [W-1:0] w2,
                           input logic [W-1:0] w3, input logic [W-1:0] w4, input logic [W-1:0] w5);
    pair_t p;
    p.x = {w2, w1, w0};
    p.y = {w5, w4, w3};
    sb_q.push_back(p);
    src_q.push_back(w0); src_q.push_back(w1); src_q.push_back(w2);
    src_q.push_back(w3); src_q.push_back(w4); src_q.push_back(w5);
  endtask

  task automatic push_random_pair();
    push_pair($urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom());
  endtask

  // One clock: drive upstream, sample at negedge, account pops/writes, step edge.
  task automatic tick();
    pair_t exp_p;
    if (!hold_inputs) begin
      in_empty = (src_q.size() == 0) || gap;
      in_dout  = (src_q.size() == 0) ? '0 : src_q[0];
    end
    @(negedge clock);
    last_rd = in_rd_en;
    last_wr = out_wr_en;
    check("rd_and_wr_same_cycle", 128'(in_rd_en & out_wr_en), '0);
    if (reset) begin
      check("reset_rd_en", 128'(in_rd_en), '0);
      check("reset_wr_en", 128'(out_wr_en), '0);
    end
    if (in_rd_en === 1'b1) begin
      check("pop_while_empty", 128'(in_empty), '0);
      if (src_q.size() > 0) void'(src_q.pop_front());
      pop_cyc.push_back(cyc);
      pops++;
    end
    if (out_wr_en === 1'b1) begin
      check("write_while_full", 128'(out_full), '0);
      if (sb_q.size() == 0) begin
        check("unexpected_write", 128'(out_wr_en), '0);
      end else begin
        exp_p = sb_q.pop_front();
        check("pair_x", 128'(out_x), 128'(exp_p.x));
        check("pair_y", 128'(out_y), 128'(exp_p.y));
      end
      writes++;
      write_cyc.push_back(cyc);
      exp_pairs++;
    end
    @(posedge clock);
    #1;
    if (reset) exp_pairs = '0;
    else if (last_wr) check("pairs_written", 128'(pairs_written), 128'(exp_pairs));
    cyc++;
    if (sparse) gap = ~gap;
  endtask

  task automatic run_until(input int target, input int budget);
    for (int i = 0; i < budget && writes < target; i++) tick();
    check("write_timeout", 128'(writes), 128'(target));
  endtask

  initial begin
    pair_t p;
    int    base;
    int    p0;

    // T1: reset held two cycles with a non-empty upstream
    reset       = 1'b1;
    out_full    = 1'b0;
    hold_inputs = 1'b1;
    in_empty    = 1'b0;
    in_dout     = 32'hDEAD_BEEF;
    tick();
    tick();
    check("t1_out_x", 128'(out_x), '0);
    check("t1_out_y", 128'(out_y), '0);
    check("t1_pairs_written", 128'(pairs_written), '0);
    reset       = 1'b0;
    hold_inputs = 1'b0;

    // T2: single pair, no stalls
    pop_cyc.delete();
    write_cyc.delete();
    push_pair(32'd1024, 32'd2048, 32'd3072, 32'hFFFF_FC00, 32'd512, 32'd0);
    run_until(writes + 1, 20);
    check("t2_pop_count", 128'(pop_cyc.size()), 128'd6);
    if (pop_cyc.size() == 6 && write_cyc.size() == 1) begin
      check("t2_pop_span", 128'(pop_cyc[5] - pop_cyc[0]), 128'd5);
      check("t2_write_after_last_pop", 128'(write_cyc[0] - pop_cyc[5]), 128'd1);
    end
    check("t2_pairs_written", 128'(pairs_written), 128'd1);

    // T3: back-pressure from the vector FIFO with more data waiting upstream
    out_full = 1'b1;
    push_random_pair();
    push_random_pair();
    p0 = pops;
    repeat (6) tick();
    check("t3_pops_before_stall", 128'(pops - p0), 128'd6);
    p = sb_q[0];
    repeat (5) begin
      tick();
      check("t3_stall_wr_en", 128'(last_wr), '0);
      check("t3_stall_rd_en", 128'(last_rd), '0);
      check("t3_hold_x", 128'(out_x), 128'(p.x));
      check("t3_hold_y", 128'(out_y), 128'(p.y));
    end
    out_full = 1'b0;
    base = writes;
    tick();
    check("t3_release_write", 128'(writes - base), 128'd1);
    tick();
    check("t3_resume_pop", 128'(last_rd), 128'd1);
    run_until(base + 2, 20);

    // T4: upstream empty every other cycle
    sparse = 1'b1;
    gap    = 1'b0;
    push_random_pair();
    push_random_pair();
    p0 = pops;
    run_until(writes + 2, 60);
    sparse = 1'b0;
    gap    = 1'b0;
    check("t4_pop_count", 128'(pops - p0), 128'd12);

    // T5: reset in the middle of a pair discards the partial data
    p0 = pops;
    repeat (4) src_q.push_back($urandom());
    repeat (4) tick();
    check("t5_partial_pops", 128'(pops - p0), 128'd4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    push_pair(32'h1111_0001, 32'h2222_0002, 32'h3333_0003,
              32'h8444_0004, 32'h5555_0005, 32'hF666_0006);
    run_until(writes + 1, 20);
    check("t5_pairs_written", 128'(pairs_written), 128'd1);

    // T6: 17 back-to-back pairs, counter wraps through 16
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 17; i++) push_random_pair();
    write_cyc.delete();
    run_until(writes + 17, 17 * 7 + 30);
    for (int i = 1; i < write_cyc.size(); i++)
      check("t6_cadence", 128'(write_cyc[i] - write_cyc[i-1]), 128'd7);
    check("t6_pairs_written", 128'(pairs_written), 128'd1);
    check("t6_scoreboard_drained", 128'(sb_q.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
